// File: rtl/uart_receive.sv
// ============================================================================
// uart_receive : 8N1 UART receiver, mid-bit sampling, 1-cycle valid/error strobes
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_receive #(
  parameter int BAUD    = 115200,
  parameter int CLK_MHZ = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CPB   = (CLK_MHZ * 1_000_000) / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic [7:0]       data_byte_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             busy_q;
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;

  logic             w_fall;

  // Start is recognised only on a genuine 1->0 transition of the synchronised line.
  assign w_fall = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_q        <= 3'd0;
      shreg_q      <= 8'h00;
      data_byte_q  <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          cnt_q <= CNT_ZERO;
          if (w_fall) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= CNT_ZERO;
            bit_q <= 3'd0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            shreg_q <= {rx_s_q, shreg_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= CNT_ZERO;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (rx_s_q) begin
              data_byte_q  <= shreg_q;
              data_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_byte  = data_byte_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
